spi_reg_bridge: RTL

//  SPI-slave (mode 0) front end that initiates accesses on the PID register file's port.
//  - Each SPI frame carries one command byte followed by one 16-bit data word.
//  - Each frame is turned into one write strobe, or one read whose result is shifted out on MISO.
//  - It sits between the external host SPI pins and the register file's write_enable/w_addr/w_data/r_addr/r_data.

---
 rtl/spi_reg_bridge.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   SPI mode-0 slave that turns each host frame (8-bit command, then a
//   DATA_W-bit word, MSB first) into one register-file write strobe, or one
//   register read whose result is shifted back out on MISO.
//
//   Command byte: bit 7 = RW (1 = read), bits 6:0 = register address.
//
// Ports
//   clk_in        system clock, rising edge
//   reset         synchronous, active low
//   spi_sclk      host SPI clock (asynchronous to clk_in, <= clk_in/8)
//   spi_cs_n      host chip select, active low
//   spi_mosi      host -> bridge data
//   spi_miso      bridge -> host data (always driven, 0 when idle)
//   write_enable  one-cycle write strobe
//   w_addr/w_data write address/data, held until the next write
//   r_addr        read address, held between reads
//   r_data_i      read data, valid one clk_in after r_addr
//   frame_abort   one-cycle pulse when a frame is discarded
//
// Build option
//   REG_WR_PROTECT_EN : writes to addresses >= RO_BASE are suppressed and
//                       reported through frame_abort instead.
`timescale 1ns/1ps

module spi_reg_bridge #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RO_BASE     = 14
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              write_enable,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data_i,
  output logic              frame_abort
);

`ifdef REG_WR_PROTECT_EN
  localparam bit WrProtect = 1'b1;
`else
  localparam bit WrProtect = 1'b0;
`endif

  localparam int unsigned CW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RD_REQ,
    S_RD_CAP,
    S_DATA,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   armed_q;      // CS_N seen high since reset / last frame
  logic [CW-1:0]          bit_cnt_q;
  logic [7:0]             cmd_q;
  logic [DATA_W-1:0]      rx_q;
  logic [DATA_W-1:0]      tx_q;
  logic                   data_rise_q;  // first data-phase rise already seen
  logic                   wr_pend_q;

  logic              sclk_s;
  logic              cs_s;
  logic              mosi_s;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              in_frame;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [ADDR_W-1:0] frame_addr;
  logic              wr_blocked;

  always_comb begin
    sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    cs_s         = cs_sync_q[SYNC_STAGES-1];
    mosi_s       = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise    = sclk_s & ~sclk_prev_q;
    sclk_fall    = ~sclk_s & sclk_prev_q;
    in_frame     = (state_q == S_CMD) || (state_q == S_RD_REQ) ||
                   (state_q == S_RD_CAP) || (state_q == S_DATA);
    // Address as it will stand once the 8th command bit is shifted in.
    rd_addr_next      = '0;
    rd_addr_next[6:0] = {cmd_q[5:0], mosi_s};
    frame_addr        = '0;
    frame_addr[6:0]   = cmd_q[6:0];
    wr_blocked        = WrProtect && (frame_addr >= ADDR_W'(RO_BASE));
  end

  // MISO is the tx MSB; tx stays zero outside the data phase of a read.
  assign spi_miso = tx_q[DATA_W-1];

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sclk_sync_q  <= '0;
      // Reset to "selected" so a CS_N held low across reset release is not
      // mistaken for the start of a fresh frame.
      cs_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      bit_cnt_q    <= '0;
      cmd_q        <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      data_rise_q  <= 1'b0;
      wr_pend_q    <= 1'b0;
      write_enable <= 1'b0;
      w_addr       <= '0;
      w_data       <= '0;
      r_addr       <= '0;
      frame_abort  <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q  <= sclk_s;
      write_enable <= 1'b0;
      frame_abort  <= 1'b0;

      if (in_frame && cs_s) begin
        // Deselect before completion: drop the frame. Takes priority over
        // any SCLK edge seen in the same cycle.
        state_q     <= S_IDLE;
        frame_abort <= 1'b1;
        tx_q        <= '0;
        armed_q     <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cs_s) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q     <= S_CMD;
              armed_q     <= 1'b0;
              bit_cnt_q   <= '0;
              cmd_q       <= '0;
              rx_q        <= '0;
              tx_q        <= '0;
              data_rise_q <= 1'b0;
              wr_pend_q   <= 1'b0;
            end
          end

          S_CMD: begin
            if (sclk_rise) begin
              cmd_q <= {cmd_q[6:0], mosi_s};
              if (bit_cnt_q == CW'(7)) begin
                bit_cnt_q <= '0;
                if (cmd_q[6]) begin
                  state_q <= S_RD_REQ;
                  r_addr  <= rd_addr_next;
                end else begin
                  state_q <= S_DATA;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + CW'(1);
              end
            end
          end

          S_RD_REQ: state_q <= S_RD_CAP;

          S_RD_CAP: begin
            tx_q    <= r_data_i;
            state_q <= S_DATA;
          end

          S_DATA: begin
            if (sclk_rise) begin
              rx_q        <= {rx_q[DATA_W-2:0], mosi_s};
              data_rise_q <= 1'b1;
              bit_cnt_q   <= bit_cnt_q + CW'(1);
              if (bit_cnt_q == CW'(DATA_W - 1)) begin
                state_q   <= S_DONE;
                wr_pend_q <= 1'b1;
                tx_q      <= '0;
              end
            end else if (sclk_fall && data_rise_q) begin
              tx_q <= tx_q << 1;
            end
          end

          S_DONE: begin
            if (wr_pend_q) begin
              wr_pend_q <= 1'b0;
              if (!cmd_q[7]) begin
                if (wr_blocked) begin
                  frame_abort <= 1'b1;
                end else begin
                  write_enable <= 1'b1;
                  w_addr       <= frame_addr;
                  w_data       <= rx_q;
                end
              end
            end
            if (cs_s) begin
              state_q <= S_IDLE;
              armed_q <= 1'b1;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
